// File: rtl/ring_seq_checker.sv
// Receive-side checker for a one-hot ring counter: decodes the set bit and tracks rotate-right lock.
// Optional saturating error counter: define RING_SEQ_ERR_CNT_EN to add the err_cnt port.
//
// state  | meaning
// HUNT   | no trusted reference word yet; waiting for any one-hot sample
// CHECK  | reference held; counting consecutive good rotate-right steps
// LOCKED | sequence verified; any deviation raises step_err
module ring_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int IDXW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] ring_in,
    output logic [IDXW-1:0]  idx,
    output logic             onehot_ok,
    output logic             locked,
    output logic             step_err,
    output logic             wrap
`ifdef RING_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    localparam int GCW = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [GCW-1:0]   good_cnt_q, good_cnt_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             onehot_ok_q, onehot_ok_d;
    logic             locked_q, locked_d;
    logic             step_err_q, step_err_d;
    logic             wrap_q, wrap_d;
`ifdef RING_SEQ_ERR_CNT_EN
    logic [7:0]       err_cnt_q, err_cnt_d;
`endif

    logic             is_onehot;
    logic [IDXW-1:0]  set_pos;
    logic [WIDTH-1:0] expect_word;
    logic             good_step;
    logic [GCW-1:0]   good_cnt_inc;

    always_comb begin
        set_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (ring_in[i]) set_pos = IDXW'(i);
        end
    end

    // The ring counter rotates right; a good step is the previous word rotated by one.
    assign is_onehot    = $onehot(ring_in);
    assign expect_word  = {prev_q[0], prev_q[WIDTH-1:1]};
    assign good_step    = is_onehot && (ring_in == expect_word);
    assign good_cnt_inc = good_cnt_q + GCW'(1);

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        good_cnt_d  = good_cnt_q;
        idx_d       = idx_q;
        onehot_ok_d = onehot_ok_q;
        locked_d    = locked_q;
        step_err_d  = 1'b0;
        wrap_d      = 1'b0;

        if (en) begin
            onehot_ok_d = is_onehot;
            if (is_onehot) begin
                idx_d  = set_pos;
                prev_d = ring_in;
            end

            case (state_q)
                HUNT: begin
                    if (is_onehot) begin
                        state_d    = CHECK;
                        good_cnt_d = '0;
                    end
                end
                CHECK: begin
                    if (good_step) begin
                        good_cnt_d = good_cnt_inc;
                        if (good_cnt_inc == GCW'(LOCK_CNT)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (is_onehot) begin
                        good_cnt_d = '0;
                    end else begin
                        state_d    = HUNT;
                        good_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (good_step) begin
                        wrap_d = prev_q[0];
                    end else begin
                        step_err_d = 1'b1;
                        locked_d   = 1'b0;
                        good_cnt_d = '0;
                        state_d    = is_onehot ? CHECK : HUNT;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    good_cnt_d = '0;
                    locked_d   = 1'b0;
                end
            endcase
        end
    end

`ifdef RING_SEQ_ERR_CNT_EN
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (step_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            prev_q      <= '0;
            good_cnt_q  <= '0;
            idx_q       <= '0;
            onehot_ok_q <= 1'b0;
            locked_q    <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef RING_SEQ_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_cnt_q  <= good_cnt_d;
            idx_q       <= idx_d;
            onehot_ok_q <= onehot_ok_d;
            locked_q    <= locked_d;
            step_err_q  <= step_err_d;
            wrap_q      <= wrap_d;
`ifdef RING_SEQ_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    assign idx       = idx_q;
    assign onehot_ok = onehot_ok_q;
    assign locked    = locked_q;
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;
`ifdef RING_SEQ_ERR_CNT_EN
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_ring_seq_checker.sv
// Bench for ring_seq_checker: directed scenarios plus random samples against a sequence-level model.
module tb_ring_seq_checker;

    localparam int W  = 4;
    localparam int LC = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] ring_in;
    logic [1:0] idx;
    logic       onehot_ok;
    logic       locked;
    logic       step_err;
    logic       wrap;
`ifdef RING_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: m_run < 0 means no reference word; otherwise it counts good steps since the last break.
    logic [3:0] m_prev;
    logic [1:0] m_idx;
    logic       m_ok, m_locked, m_serr, m_wrap;
    int         m_run;
    int         m_errs;

    always #5 clk = ~clk;

    ring_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .IDXW(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .ring_in  (ring_in),
        .idx      (idx),
        .onehot_ok(onehot_ok),
        .locked   (locked),
        .step_err (step_err),
        .wrap     (wrap)
`ifdef RING_SEQ_ERR_CNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    function automatic logic [3:0] next_of(input logic [3:0] p);
        int v;
        v = int'(p);
        v = (v / 2) + ((v % 2) * 8);
        return v[3:0];
    endfunction

    task automatic model_reset();
        m_prev = '0; m_idx = '0; m_ok = 0; m_locked = 0;
        m_serr = 0; m_wrap = 0; m_run = -1; m_errs = 0;
    endtask

    task automatic model_clock(input logic e, input logic [3:0] r);
        bit oh, good;
        m_serr = 0;
        m_wrap = 0;
        if (!e) return;
        oh   = ($countones(r) == 1);
        good = oh && (r == next_of(m_prev));
        if (m_locked) begin
            if (good) begin
                m_wrap = (m_prev == 4'b0001);
            end else begin
                m_serr   = 1;
                m_locked = 0;
                m_run    = oh ? 0 : -1;
                if (m_errs < 255) m_errs++;
            end
        end else if (m_run < 0) begin
            if (oh) m_run = 0;
        end else if (good) begin
            m_run++;
            if (m_run >= LC) m_locked = 1;
        end else begin
            m_run = oh ? 0 : -1;
        end
        if (oh) begin
            m_ok   = 1;
            m_idx  = 2'($clog2(int'(r)));
            m_prev = r;
        end else begin
            m_ok = 0;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".idx"},       8'(idx),       8'(m_idx));
        check({tag, ".onehot_ok"}, 8'(onehot_ok), 8'(m_ok));
        check({tag, ".locked"},    8'(locked),    8'(m_locked));
        check({tag, ".step_err"},  8'(step_err),  8'(m_serr));
        check({tag, ".wrap"},      8'(wrap),      8'(m_wrap));
`ifdef RING_SEQ_ERR_CNT_EN
        check({tag, ".err_cnt"},   err_cnt,       8'(m_errs));
`endif
    endtask

    task automatic step(input string tag, input logic e, input logic [3:0] r);
        en      = e;
        ring_in = r;
        @(posedge clk);
        model_clock(e, r);
        #1;
        check_all(tag);
    endtask

    task automatic lock_up();
        step("lu_brk", 1'b1, 4'b0110);
        step("lu_s0", 1'b1, 4'b1000);
        step("lu_s1", 1'b1, 4'b0100);
        step("lu_s2", 1'b1, 4'b0010);
        step("lu_s3", 1'b1, 4'b0001);
    endtask

    initial begin
        logic [3:0] r;
        logic       e;
        rst = 1'b1; en = 1'b0; ring_in = '0;
        model_reset();
        #12;
        rst = 1'b0;
        check_all("reset");

        // Lock acquisition
        step("acq0", 1'b1, 4'b1000); check("acq0_idx", 8'(idx), 8'd3);
        step("acq1", 1'b1, 4'b0100); check("acq1_idx", 8'(idx), 8'd2);
        step("acq2", 1'b1, 4'b0010); check("acq2_idx", 8'(idx), 8'd1);
        check("acq2_unlocked", 8'(locked), 8'd0);
        step("acq3", 1'b1, 4'b0001); check("acq3_idx", 8'(idx), 8'd0);
        check("acq3_locked", 8'(locked), 8'd1);

        // Wrap from 0001 to 1000
        step("wrap0", 1'b1, 4'b1000);
        check("wrap0_pulse", 8'(wrap), 8'd1);
        check("wrap0_idx", 8'(idx), 8'd3);
        step("wrap1", 1'b1, 4'b0100);
        check("wrap1_clear", 8'(wrap), 8'd0);

        // One-hot step error with prev=1000
        step("pre0", 1'b1, 4'b0010);
        step("pre1", 1'b1, 4'b0001);
        step("pre2", 1'b1, 4'b1000);
        step("ohe", 1'b1, 4'b0010);
        check("ohe_err", 8'(step_err), 8'd1);
        check("ohe_unlock", 8'(locked), 8'd0);
        check("ohe_idx", 8'(idx), 8'd1);
        step("rl0", 1'b1, 4'b0001);
        check("rl0_errclr", 8'(step_err), 8'd0);
        step("rl1", 1'b1, 4'b1000);
        step("rl2", 1'b1, 4'b0100);
        check("rl2_locked", 8'(locked), 8'd1);
`ifdef RING_SEQ_ERR_CNT_EN
        check("ohe_errcnt", err_cnt, 8'd1);
`endif

        // Non-one-hot while locked
        step("noh", 1'b1, 4'b0110);
        check("noh_ok", 8'(onehot_ok), 8'd0);
        check("noh_idx", 8'(idx), 8'd2);
        check("noh_err", 8'(step_err), 8'd1);
        step("zero", 1'b1, 4'b0000);
        check("zero_noerr", 8'(step_err), 8'd0);

        // Idle with toggling input
        step("idl_a", 1'b1, 4'b1000);
        step("idl_b", 1'b1, 4'b0100);
        step("idl_c", 1'b1, 4'b0010);
        step("idl_d", 1'b1, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            r = 4'($urandom);
            step("idle", 1'b0, r);
        end
        check("idle_locked", 8'(locked), 8'd1);
        step("idl_resume", 1'b1, 4'b1000);
        check("resume_locked", 8'(locked), 8'd1);
        check("resume_noerr", 8'(step_err), 8'd0);

        // Random traffic biased toward correct rotation
        for (int i = 0; i < 400; i++) begin
            e = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 9))
                0, 1:    r = 4'($urandom);
                2:       r = 4'b0001 << $urandom_range(0, 3);
                3:       r = m_prev;
                default: r = (m_prev == 4'b0000) ? 4'b1000 : next_of(m_prev);
            endcase
            step("rand", e, r);
        end

        // Asynchronous reset while locked
        lock_up();
        check("pre_rst_locked", 8'(locked), 8'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst0", 1'b1, 4'b0100);
        check("post_rst_idx", 8'(idx), 8'd2);
        check("post_rst_noerr", 8'(step_err), 8'd0);
        step("post_rst1", 1'b1, 4'b0010);

`ifdef RING_SEQ_ERR_CNT_EN
        for (int i = 0; i < 300; i++) begin
            lock_up();
        end
        step("sat_last", 1'b1, 4'b0110);
        check("sat_errcnt", err_cnt, 8'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_seq_checker.md
Name: ring_seq_checker

Overview:
- Receive-side companion for the 4-bit one-hot ring counter in the counter library.
- Samples a one-hot ring word, decodes it to a binary bit index, and checks that each sample is exactly one rotation step from the previous one.
- Acquires lock after a run of good steps and flags step errors while locked.
- Used wherever a ring counter drives phase/slot selection and that sequence must be monitored.

Parameters:
- WIDTH, 4, ring word width; must be >= 2.
- LOCK_CNT, 3, consecutive good steps needed to enter LOCKED; must be >= 1.
- IDXW, 2, index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state immediately.
- en  input  1  sample strobe; ring_in is evaluated only when en=1.
- ring_in  input  WIDTH  ring word from the source counter.
- idx  output  IDXW  bit position of the set bit in the last valid one-hot sample.
- onehot_ok  output  1  last sampled word had exactly one bit set.
- locked  output  1  sequence lock acquired.
- step_err  output  1  one-cycle pulse on a sequence violation while LOCKED.
- wrap  output  1  one-cycle pulse on the bit0 -> bit(WIDTH-1) step while LOCKED.
- err_cnt  output  8  saturating error count; present only with the macro.

Behaviour:
- Reset values: idx=0, onehot_ok=0, locked=0, step_err=0, wrap=0, err_cnt=0, state=HUNT, prev=0, good_cnt=0.
- All outputs are registered. Latency is 1 clock from the sampling edge.
- Expected step is a rotate-right by one: next = {prev[0], prev[WIDTH-1:1]}. Example: 1000 -> 0100 -> 0010 -> 0001 -> 1000.
- en=0: all state and outputs hold, except step_err and wrap, which return to 0. No checking occurs.
- en=1, one-hot sample: onehot_ok<=1, idx<=set-bit position, prev<=ring_in.
- en=1, non-one-hot sample (zero or multiple bits): onehot_ok<=0; idx and prev hold.
- State machine (transitions only on en=1):
  - HUNT: one-hot sample -> CHECK with good_cnt=0. Otherwise stay in HUNT.
  - CHECK:
    - sample == rotr(prev): good_cnt+1; on reaching LOCK_CNT -> LOCKED, locked<=1.
    - one-hot mismatch: stay in CHECK with good_cnt=0 (new prev).
    - non-one-hot: -> HUNT.
  - LOCKED:
    - sample == rotr(prev): stay in LOCKED.
    - Any mismatch, including repeat/stall (sample == prev), wrong direction, or non-one-hot: step_err<=1 and locked<=0. Next state is CHECK (good_cnt=0) if the sample is one-hot, else HUNT.
- wrap<=1 when LOCKED, prev[0]=1, and sample has bit WIDTH-1 set as a good step.
- good_cnt width is clog2(LOCK_CNT+1) and never exceeds LOCK_CNT.
- rst asserted mid-operation: all registers clear asynchronously. The first en sample after deassertion is treated as in HUNT.
- step_err and wrap are never asserted in the same cycle.

Optional Feature:
- Macro RING_SEQ_ERR_CNT_EN.
- Defined:
  - err_cnt port and an 8-bit counter are present.
  - The counter increments on every step_err pulse and saturates at 255.
  - Cleared only by rst.
- Undefined: the err_cnt port and its logic are absent. All other behaviour is identical.

Test Plan:
- Lock acquisition (WIDTH=4, LOCK_CNT=3): after rst, drive en=1 with 1000, 0100, 0010, 0001 on consecutive cycles.
  - idx=3, 2, 1, 0.
  - locked=1 one cycle after the 4th sample.
  - step_err=0 throughout.
- Wrap: while locked, drive 0001 then 1000.
  - wrap=1 for exactly one cycle after the 1000 sample; idx=3; locked stays 1.
- One-hot step error: locked with prev=1000, drive 0010 instead of the expected 0100.
  - step_err pulses once; locked=0; idx=1.
  - Then drive 0001, 1000, 0100: locked=1 again after the third good step.
  - err_cnt=1 with the macro.
- Non-one-hot while locked: drive 0110.
  - onehot_ok=0, idx holds, step_err pulses, state=HUNT.
  - Then drive 0000: no further step_err.
- Idle: locked, en=0 for 5 cycles with ring_in toggling randomly.
  - All outputs hold; no step_err, no wrap.
  - The next correctly rotated sample keeps lock.
- Async reset and saturation: assert rst between clock edges while locked.
  - All outputs are 0 before the next clk edge.
  - With the macro, force 300 errors: err_cnt stops at 255.
